// File: rtl/gravity_led_animator.sv
// Free-fall LED animator: a ticked time ramp t is squared to a distance and shown as one lit LED.
// Supports waterfall (wrap to top) and bounce (retrace upward) motion.
module gravity_led_animator #(
  parameter int unsigned TICK_DIV = 381,
  parameter int unsigned T_BITS   = 17,
  parameter int unsigned N_LEDS   = 16,
  parameter int unsigned P_BITS   = $clog2(N_LEDS)
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              run,
  input  logic              mode,
  output logic [N_LEDS-1:0] LED,
  output logic [P_BITS-1:0] pos,
  output logic [T_BITS-1:0] t_out,
  output logic              hit
);

  localparam int unsigned       TB_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned       SQ_W    = 2 * T_BITS;
  localparam logic [TB_W-1:0]   TB_LAST = TB_W'(TICK_DIV - 1);
  localparam logic [T_BITS-1:0] T_MAX   = '1;

  typedef enum logic {UP, DOWN} dir_t;

  dir_t              state, state_next;
  logic [TB_W-1:0]   tb_cnt;
  logic              tick;
  logic [T_BITS-1:0] t_next;
  logic              hit_next;
  logic [SQ_W-1:0]   tsq;
  logic              sq_valid;

  assign tick = run && (tb_cnt == TB_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      tb_cnt <= '0;
    end else if (run) begin
      tb_cnt <= tick ? '0 : tb_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    t_next     = t_out;
    if (tick) begin
      unique case (state)
        UP: begin
          if (t_out != T_MAX) begin
            t_next = t_out + 1'b1;
          end else if (mode) begin
            t_next     = T_MAX - 1'b1;
            state_next = DOWN;
          end else begin
            t_next = '0;
          end
        end
        DOWN: begin
          // Leaving bounce mode resumes the fall immediately rather than stalling t.
          if (!mode || t_out == '0) begin
            t_next     = t_out + 1'b1;
            state_next = UP;
          end else begin
            t_next = t_out - 1'b1;
          end
        end
      endcase
    end
    hit_next = tick && (t_next == T_MAX);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= UP;
      t_out <= '0;
      hit   <= 1'b0;
    end else begin
      state <= state_next;
      t_out <= t_next;
      hit   <= hit_next;
    end
  end

  // sq_valid keeps LED dark until tsq holds a square computed after reset.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      tsq      <= '0;
      sq_valid <= 1'b0;
      pos      <= '0;
      LED      <= '0;
    end else begin
      tsq      <= SQ_W'(t_out) * SQ_W'(t_out);
      sq_valid <= 1'b1;
      pos      <= tsq[SQ_W-1 -: P_BITS];
      LED      <= sq_valid ? (N_LEDS'(1) << tsq[SQ_W-1 -: P_BITS]) : '0;
    end
  end

endmodule

// File: doc/gravity_led_animator.md
# gravity_led_animator

Parametrised successor to the single-mode waterfall LED display. It generates a normalised time ramp from a configurable timebase and squares it to model free-fall distance (d ∝ t²). It drives one lit LED out of N_LEDS and supports two selectable modes: waterfall (fall and restart at top) and bounce (fall, then rise back along the same trajectory). It sits directly under the board top level, between CLK100MHZ and the LED bank, with run/mode fed from switches.

## Interface
- TICK_DIV, 381: timebase modulus. One tick every TICK_DIV clocks; legal range ≥2.
- T_BITS, 17: width of normalised time t (unsigned fraction, 0 ≤ t < 1); legal range 2..24.
- N_LEDS, 16: LED count; must be a power of two, 4..64.
- P_BITS, $clog2(N_LEDS): derived; not to be overridden.

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = animate; 0 = freeze timebase and t.
- mode  in  1  0 = WATERFALL, 1 = BOUNCE; sampled on each tick.
- LED  out  N_LEDS  one-hot position, LED[0] = top.
- pos  out  P_BITS  binary index of lit LED.
- t_out  out  T_BITS  current time register.
- hit  out  1  one-cycle pulse when the ball reaches the bottom (t = max).

## Operation
- Timebase: counter tb counts 0..TICK_DIV-1 while run=1 and holds while run=0. tick=1 for the single cycle where tb==TICK_DIV-1 and run=1; tb then wraps to 0.
- Direction FSM has two states, UP (t incrementing, ball falling) and DOWN (t decrementing, ball rising). It only acts on tick:
  - UP, t<max: t+1.
  - UP, t==max, mode=0: t←0, stay UP.
  - UP, t==max, mode=1: t←max-1, go DOWN.
  - DOWN, t>0, mode=1: t−1.
  - DOWN, t==0: t←1, go UP.
  - DOWN, mode=0 sampled: go UP and t+1 on that same tick. A mode change never stalls t.
- Distance: tsq = t*t (2·T_BITS bits, unsigned, full precision, no truncation before indexing). pos = tsq[2·T_BITS-1 -: P_BITS], i.e. floor(t² · N_LEDS).
- LED = one-hot of pos. Exactly one bit is set after pipeline fill.
- hit: asserted for the one cycle in which t_out first equals max after a tick.
- run=0 mid-fall: t, the FSM and tb hold. The display stays static; no tick is lost or duplicated on resume.

## Timing
- Reset (sync): tb=0, t_out=0, FSM=UP, tsq=0, pos=0, LED=0, hit=0.
- Pipeline: t registered on tick edge (cycle 0). tsq is registered at cycle +1. pos and LED are registered at cycle +2. LED latency from t change is therefore 2 clocks.
- After reset deassert, LED becomes 1 (LED[0]) at the 2nd rising edge.
- Tick period is exactly TICK_DIV clocks.
- WATERFALL full period = 2^T_BITS ticks.
- BOUNCE full period = 2·(2^T_BITS − 1) ticks. t dwells at max and at 0 for one tick each.
- hit is registered alongside t_out, not delayed by the pipeline.
- If reset and tick coincide, reset wins.
- Defaults give a 100 MHz, 381-clock tick, i.e. a 3.81 µs tick and a fall time of ≈0.499 s.

## Test plan
Parameters for all scenarios: TICK_DIV=4, T_BITS=4, N_LEDS=4.
- Reset and timebase: hold reset 3 clocks, then release → all outputs 0. Ticks occur every 4 clocks. t_out=1 after the 4th edge, and LED=4'b0001 from the 2nd edge.
- Waterfall sweep, mode=0: step t through 0..15 → pos follows t=0..7:0, 8..11:1 (t=8 gives 64=0x40), 12..13:2 (t=12 gives 144=0x90), 14..15:3 (t=15 gives 225). hit pulses once at t=15, and the next tick gives t=0.
- Bounce, mode=1 → t goes 14,15,14,…,1,0,1. hit pulses once per period. Period is 30 ticks (120 clocks). LED returns to 4'b0001.
- Mode switch mid-descent: in DOWN at t=9, set mode=0 → next tick gives t=10 in UP, then the sequence 15→0 wraps.
- Pause: run=0 for 50 clocks at t=6 → t_out, LED and tb remain constant. On run=1 the next tick arrives after the remaining tb count, not a full TICK_DIV.
- Reset mid-flight: assert reset in DOWN at t=11 → next edge gives t_out=0, FSM=UP, LED=0, hit=0.
